id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 151 +++++++++++++++
 tb/tb_id_ex_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes a MIPS word, bypasses writeback data,
// and inserts one bubble on load-use hazards. Holds one payload (EMPTY/FULL/BUBBLE).
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              wb_wr,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rd,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic              ex_mem_read,
    output logic              ex_reg_wr,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {EMPTY, FULL, BUBBLE} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rd;
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic              mem_read;
        logic              reg_wr;
    } payload_t;

    state_t     state, state_nxt;
    payload_t   pay, dec;
    logic [5:0] opcode, funct;
    logic [4:0] rs, rt;
    logic       uses_rt, hazard, accept;
    logic       clear, stall_inc;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign funct  = instr[5:0];

    always_comb begin
        dec          = '0;
        dec.opcode   = opcode;
        dec.funct    = funct;
        dec.imm      = {{(DATA_W-16){instr[15]}}, instr[15:0]};
        dec.rd       = (opcode == 6'h00) ? instr[15:11] : rt;
        dec.mem_read = (opcode == 6'h23);
        // Register 0 reads as zero even if a writeback targets it.
        if (rs == 5'd0)
            dec.rs_val = '0;
        else if (wb_wr && wb_addr == rs)
            dec.rs_val = wb_data;
        else
            dec.rs_val = rs_data;
        if (rt == 5'd0)
            dec.rt_val = '0;
        else if (wb_wr && wb_addr == rt)
            dec.rt_val = wb_data;
        else
            dec.rt_val = rt_data;
        unique case (1'b1)
            opcode == 6'h00:       dec.reg_wr = (funct != 6'h08);
            opcode == 6'h23:       dec.reg_wr = 1'b1;
            opcode[5:3] == 3'b001: dec.reg_wr = 1'b1;
            default:               dec.reg_wr = 1'b0;
        endcase
    end

    // rt is a true source only for R-type, sw, beq and bne.
    assign uses_rt = (opcode == 6'h00) || (opcode == 6'h2B) ||
                     (opcode == 6'h04) || (opcode == 6'h05);

    assign hazard = out_valid && pay.mem_read && pay.reg_wr &&
                    (pay.rd != 5'd0) &&
                    ((pay.rd == rs) || ((pay.rd == rt) && uses_rt));

    assign in_ready = !flush && !hazard && (state != FULL || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        stall_inc = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept)
                    state_nxt = FULL;
            end
            FULL: begin
                if (accept) begin
                    state_nxt = FULL;
                end else if (out_ready && in_valid && hazard) begin
                    state_nxt = BUBBLE;
                    clear     = 1'b1;
                    stall_inc = 1'b1;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            BUBBLE: state_nxt = accept ? FULL : EMPTY;
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt = EMPTY;
            clear     = 1'b1;
            stall_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            pay         <= '0;
            stall_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                pay <= dec;
            else if (clear)
                pay <= '0;
            if (stall_inc && stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + 1'b1;
        end
    end

    assign out_valid   = (state == FULL);
    assign ex_rs_val   = pay.rs_val;
    assign ex_rt_val   = pay.rt_val;
    assign ex_imm      = pay.imm;
    assign ex_rd       = pay.rd;
    assign ex_opcode   = pay.opcode;
    assign ex_funct    = pay.funct;
    assign ex_mem_read = pay.mem_read;
    assign ex_reg_wr   = pay.reg_wr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic
// compared against a transaction-level model of the stage.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int SMAX = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   instr = '0;
    logic [DW-1:0] rs_data = '0;
    logic [DW-1:0] rt_data = '0;
    logic          wb_wr = 1'b0;
    logic [4:0]    wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]    ex_rd;
    logic [5:0]    ex_opcode, ex_funct;
    logic          ex_mem_read, ex_reg_wr;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    bit          m_valid = 0;
    int          m_stall = 0;
    int unsigned e_rs = 0, e_rt = 0, e_imm = 0;
    int          e_rd = 0, e_op = 0, e_fn = 0;
    bit          e_mr = 0, e_rw = 0;

    id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_mem_read(ex_mem_read), .ex_reg_wr(ex_reg_wr),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_op(int s, int t, int d, int fn);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_op(int op, int s, int t, int imm);
        return {6'(op), 5'(s), 5'(t), 16'(imm)};
    endfunction

    function automatic int unsigned operand(int r, int unsigned d);
        if (r == 0) return 0;
        if (wb_wr && wb_addr == 5'(r)) return wb_data;
        return d;
    endfunction

    function automatic bit model_hazard();
        int op = int'(instr[31:26]);
        int s = int'(instr[25:21]);
        int t = int'(instr[20:16]);
        bit rt_src = (op == 0) || (op == 43) || (op == 4) || (op == 5);
        return m_valid && e_mr && e_rw && e_rd != 0 &&
               (e_rd == s || (e_rd == t && rt_src));
    endfunction

    task automatic check_outputs();
        check("out_valid", out_valid, m_valid);
        check("stall_count", stall_count, m_stall);
        check("ex_mem_read", ex_mem_read, e_mr);
        check("ex_reg_wr", ex_reg_wr, e_rw);
        if (m_valid) begin
            check("ex_rs_val", ex_rs_val, e_rs);
            check("ex_rt_val", ex_rt_val, e_rt);
            check("ex_imm", ex_imm, e_imm);
            check("ex_rd", ex_rd, e_rd);
            check("ex_opcode", ex_opcode, e_op);
            check("ex_funct", ex_funct, e_fn);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input logic [31:0] i,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit ww, input logic [4:0] wa,
                        input logic [31:0] wd, input bit fl,
                        input bit ordy, output bit rdy);
        bit haz, exp_rdy;
        int op, fn;
        in_valid = v; instr = i; rs_data = a; rt_data = b;
        wb_wr = ww; wb_addr = wa; wb_data = wd;
        flush = fl; out_ready = ordy;
        #1;
        haz = model_hazard();
        exp_rdy = !fl && !haz && (!m_valid || ordy);
        rdy = in_ready;
        check("in_ready", in_ready, exp_rdy);
        if (fl) begin
            m_valid = 0; e_mr = 0; e_rw = 0;
        end else if (v && exp_rdy) begin
            op = int'(i >> 26);
            fn = int'(i & 32'h3F);
            e_op = op; e_fn = fn;
            e_rd = (op == 0) ? int'((i >> 11) & 31) : int'((i >> 16) & 31);
            e_imm = i[15] ? ((i & 32'hFFFF) | 32'hFFFF0000) : (i & 32'hFFFF);
            e_mr = (op == 35);
            e_rw = (op == 0) ? (fn != 8) : (op == 35 || (op >= 8 && op <= 15));
            e_rs = operand(int'((i >> 21) & 31), a);
            e_rt = operand(int'((i >> 16) & 31), b);
            m_valid = 1;
        end else if (m_valid && ordy && v && haz) begin
            m_valid = 0; e_mr = 0; e_rw = 0;
            if (m_stall < SMAX) m_stall++;
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_stall", stall_count, 0);
        check("rst_reg_wr", ex_reg_wr, 0);
        reset = 1'b0;
        m_valid = 0; m_stall = 0;
        e_rs = 0; e_rt = 0; e_imm = 0; e_rd = 0; e_op = 0; e_fn = 0;
        e_mr = 0; e_rw = 0;
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rnd_instr();
        int op;
        int fn;
        case ($urandom_range(0, 7))
            0: op = 0;
            1: op = 35;
            2: op = 43;
            3: op = 4;
            4: op = 5;
            5: op = 8;
            6: op = 13;
            default: op = 2;
        endcase
        fn = ($urandom_range(0, 3) == 0) ? 8 : int'($urandom_range(0, 63));
        return {6'(op), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom), 6'(fn)};
    endfunction

    initial begin
        bit rdy;
        #7;
        check("reset_out_valid", out_valid, 0);
        check("reset_ex_all",
              {ex_rs_val, ex_rt_val}, 64'd0);
        check("reset_ex_rest",
              {ex_imm, ex_rd, ex_opcode, ex_funct, ex_mem_read, ex_reg_wr}, 64'd0);
        check("reset_stall", stall_count, 0);
        #1 reset = 1'b0;
        @(negedge clk);

        // add $1,$4,$5
        step(1, r_op(4, 5, 1, 32'h20), 4, 5, 0, 0, 0, 0, 1, rdy);
        check("add_valid", out_valid, 1);
        check("add_rs", ex_rs_val, 4);
        check("add_rt", ex_rt_val, 5);
        check("add_rd", ex_rd, 1);
        check("add_wr", ex_reg_wr, 1);

        // lw $6,0($4) then dependent add $7,$6,$5
        step(1, i_op(35, 4, 6, 0), 100, 200, 0, 0, 0, 0, 1, rdy);
        check("lw_mr", ex_mem_read, 1);
        step(1, r_op(6, 5, 7, 32'h20), 11, 22, 0, 0, 0, 0, 1, rdy);
        check("lu_rdy", rdy, 0);
        check("lu_bubble", out_valid, 0);
        check("lu_stall", stall_count, 1);
        step(1, r_op(6, 5, 7, 32'h20), 11, 22, 0, 0, 0, 0, 1, rdy);
        check("lu_accept", rdy, 1);
        check("lu_rd", ex_rd, 7);

        // writeback bypass and register 0
        step(1, r_op(4, 5, 8, 32'h20), 4, 5, 1, 4, 32'h55, 0, 1, rdy);
        check("byp_rs", ex_rs_val, 32'h55);
        step(1, r_op(0, 2, 3, 32'h20), 32'h99, 2, 1, 0, 32'h77, 0, 1, rdy);
        check("r0_rs", ex_rs_val, 0);

        // backpressure for three cycles
        for (int k = 0; k < 3; k++) begin
            step(1, r_op(1, 2, 9, 32'h20), 1, 2, 0, 0, 0, 0, 0, rdy);
            check("hold_rdy", rdy, 0);
            check("hold_rd", ex_rd, 3);
        end
        step(1, r_op(1, 2, 9, 32'h20), 1, 2, 0, 0, 0, 0, 1, rdy);
        check("release_rd", ex_rd, 9);

        // flush while full
        step(1, r_op(1, 2, 10, 32'h20), 1, 2, 0, 0, 0, 1, 1, rdy);
        check("flush_valid", out_valid, 0);
        check("flush_stall", stall_count, 1);

        for (int n = 0; n < 1600; n++) begin
            if (n == 700) reset_pulse();
            step($urandom_range(0, 3) != 0, rnd_instr(), $urandom, $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, rdy);
        end
        if (m_stall == SMAX)
            check("stall_sat", stall_count, SMAX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
